sha256_block_engine: RTL

Parametrised multi-block SHA-256/SHA-224 compression engine. It accepts pre-padded 512-bit message blocks over a valid/ready handshake and chains the intermediate hash across blocks. Each block is compressed iteratively at ROUNDS_PER_CYCLE rounds per clock, with an on-the-fly 16-word message schedule. The final digest is presented on a valid/ready output. It is the next-generation replacement for the fixed single-round transform wrapper in the hashing datapath.

---
 rtl/sha256_pkg.sv | 67 ++++++
 rtl/sha256_round.sv | 32 +++
 rtl/sha256_block_engine.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/sha256_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// sha256_pkg: SHA-256/224 constants, engine state and round helpers
// Rev 1.0
// ------------------------------------------------------------------
package sha256_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_ADD   = 2'd2,
    ST_OUT   = 2'd3
  } engine_state_e;

  localparam word_t K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam word_t IV256 [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam word_t IV224 [8] = '{
    32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
    32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
  };

  function automatic word_t rotr(input word_t x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic word_t big_sigma0(input word_t x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic word_t big_sigma1(input word_t x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic word_t small_sigma0(input word_t x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic word_t small_sigma1(input word_t x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic word_t ch(input word_t e, input word_t f, input word_t g);
    return (e & f) ^ (~e & g);
  endfunction

  function automatic word_t maj(input word_t a, input word_t b, input word_t c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sha256_round.sv
`default_nettype none
// ------------------------------------------------------------------
// sha256_round: one combinational SHA-256 round, state[0]=a .. state[7]=h
// Rev 1.0
// ------------------------------------------------------------------
module sha256_round
  import sha256_pkg::*;
(
  input  word_t i_state [8],
  input  word_t i_k,
  input  word_t i_w,
  output word_t o_state [8]
);

  word_t t1;
  word_t t2;

  always_comb begin
    t1 = i_state[7] + big_sigma1(i_state[4]) + ch(i_state[4], i_state[5], i_state[6]) + i_k + i_w;
    t2 = big_sigma0(i_state[0]) + maj(i_state[0], i_state[1], i_state[2]);
    o_state[0] = t1 + t2;
    o_state[1] = i_state[0];
    o_state[2] = i_state[1];
    o_state[3] = i_state[2];
    o_state[4] = i_state[3] + t1;
    o_state[5] = i_state[4];
    o_state[6] = i_state[5];
    o_state[7] = i_state[6];
  end

endmodule
`default_nettype wire

// File: rtl/sha256_block_engine.sv
`default_nettype none
// ------------------------------------------------------------------
// sha256_block_engine: multi-block SHA-256/224 compression engine
// Rev 1.0
// ------------------------------------------------------------------
module sha256_block_engine
  import sha256_pkg::*;
#(
  parameter int ROUNDS_PER_CYCLE = 1,
  parameter bit SUPPORT_224      = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         blk_vld,
  output logic         blk_rdy,
  input  logic [511:0] blk_data,
  input  logic         blk_first,
  input  logic         blk_last,
  input  logic         mode_224,
  output logic         digest_vld,
  input  logic         digest_rdy,
  output logic [255:0] digest,
  output logic         busy
);

  localparam int R = ROUNDS_PER_CYCLE;

  if (!(R == 1 || R == 2 || R == 4 || R == 8)) begin : g_bad_rounds_per_cycle
    $error("sha256_block_engine: ROUNDS_PER_CYCLE must be 1, 2, 4 or 8");
  end

  engine_state_e state_q, state_d;
  logic          chain_vld_q, chain_vld_d;
  logic          mode_224_q, mode_224_d;
  logic          last_q, last_d;
  logic [5:0]    t_q, t_d;
  word_t         h_q [8];
  word_t         h_d [8];
  word_t         wk_q [8];
  word_t         wk_d [8];
  word_t         w_q [16];
  word_t         w_d [16];
  word_t         w_shift [16];

  // Window holds W[t..t+15]; extend by R new words and slide forward by R.
  always_comb begin : p_sched
    word_t ext [16 + R];
    for (int i = 0; i < 16; i++) ext[i] = w_q[i];
    for (int j = 0; j < R; j++) begin
      ext[16 + j] = small_sigma1(ext[14 + j]) + ext[9 + j] + small_sigma0(ext[1 + j]) + ext[j];
    end
    for (int i = 0; i < 16; i++) w_shift[i] = ext[i + R];
  end

  for (genvar j = 0; j < R; j++) begin : g_round
    word_t st_in [8];
    word_t st_out [8];
    if (j == 0) begin : g_src_regs
      assign st_in = wk_q;
    end else begin : g_src_chain
      assign st_in = g_round[j - 1].st_out;
    end
    sha256_round u_round (
      .i_state (st_in),
      .i_k     (K[t_q + 6'(j)]),
      .i_w     (w_q[j]),
      .o_state (st_out)
    );
  end

  always_comb begin
    state_d     = state_q;
    chain_vld_d = chain_vld_q;
    mode_224_d  = mode_224_q;
    last_d      = last_q;
    t_d         = t_q;
    h_d         = h_q;
    wk_d        = wk_q;
    w_d         = w_q;
    blk_rdy     = 1'b0;
    digest_vld  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        blk_rdy = ~rst;
        if (blk_vld && !rst) begin
          // A block with no live chain behind it starts a message even without blk_first.
          if (blk_first || !chain_vld_q) begin
            mode_224_d = mode_224 & SUPPORT_224;
            if (mode_224_d) h_d = IV224;
            else            h_d = IV256;
          end
          wk_d   = h_d;
          last_d = blk_last;
          t_d    = '0;
          for (int i = 0; i < 16; i++) w_d[i] = blk_data[511 - 32*i -: 32];
          state_d = ST_ROUND;
        end
      end
      ST_ROUND: begin
        wk_d = g_round[R - 1].st_out;
        w_d  = w_shift;
        t_d  = t_q + 6'(R);
        if ((7'(t_q) + 7'(R)) == 7'd64) state_d = ST_ADD;
      end
      ST_ADD: begin
        for (int i = 0; i < 8; i++) h_d[i] = h_q[i] + wk_q[i];
        chain_vld_d = ~last_q;
        state_d     = last_q ? ST_OUT : ST_IDLE;
      end
      ST_OUT: begin
        digest_vld = 1'b1;
        if (digest_rdy) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      chain_vld_q <= 1'b0;
      mode_224_q  <= 1'b0;
      last_q      <= 1'b0;
      t_q         <= '0;
      for (int i = 0; i < 8; i++) begin
        h_q[i]  <= '0;
        wk_q[i] <= '0;
      end
      for (int i = 0; i < 16; i++) w_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      chain_vld_q <= chain_vld_d;
      mode_224_q  <= mode_224_d;
      last_q      <= last_d;
      t_q         <= t_d;
      h_q         <= h_d;
      wk_q        <= wk_d;
      w_q         <= w_d;
    end
  end

  always_comb begin
    digest = '0;
    if (state_q == ST_OUT) begin
      for (int i = 0; i < 8; i++) digest[255 - 32*i -: 32] = h_q[i];
      if (mode_224_q) digest[31:0] = '0;
    end
  end

  assign busy = (state_q != ST_IDLE);

endmodule
`default_nettype wire
